// File: rtl/esm_pkg.sv
// Shared definitions for the ESM front end and core.
// Holds the RV32 opcode constants recognised by the decoder, the bubble word
// injected when no instruction is available, and the decoded control bundle.
package esm_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic ALUSrc;
    logic RegWrite;
  } ctrl_t;

endpackage

// File: rtl/esm_instr_decode.sv
// Combinational control decode for one instruction word.
// Ports:
//   instr : instruction word (opcode [6:0], rd [11:7])
//   ctrl  : decoded ALUSrc / RegWrite
module esm_instr_decode
  import esm_pkg::*;
#(
  parameter int unsigned Instr_word_size = 32
) (
  input  logic [Instr_word_size-1:0] instr,
  output ctrl_t                      ctrl
);

  // Only opcode and rd matter for these two controls.
  logic unused_bits;
  assign unused_bits = ^instr[Instr_word_size-1:12];

  always_comb begin
    ctrl = '0;
    unique case (instr[6:0])
      OP_R:      begin ctrl.ALUSrc = 1'b0; ctrl.RegWrite = 1'b1; end
      OP_IMM:    begin ctrl.ALUSrc = 1'b1; ctrl.RegWrite = 1'b1; end
      OP_LOAD:   begin ctrl.ALUSrc = 1'b1; ctrl.RegWrite = 1'b1; end
      OP_STORE:  begin ctrl.ALUSrc = 1'b1; ctrl.RegWrite = 1'b0; end
      OP_BRANCH: begin ctrl.ALUSrc = 1'b0; ctrl.RegWrite = 1'b0; end
      OP_LUI:    begin ctrl.ALUSrc = 1'b1; ctrl.RegWrite = 1'b1; end
      OP_JAL:    begin ctrl.ALUSrc = 1'b1; ctrl.RegWrite = 1'b1; end
      default:   ctrl = '0;
    endcase
    // Writes to x0 are architecturally discarded.
    if (instr[11:7] == 5'd0) ctrl.RegWrite = 1'b0;
  end

endmodule

// File: rtl/esm_fetch_queue.sv
// Instruction fetch queue in front of the ESM core.
// Buffers incoming words in a FIFO, decodes ALUSrc/RegWrite from the head and
// presents one registered instruction per cycle; injects NOP_WORD when empty
// and holds outputs while the core stalls.
// Ports:
//   clk, rst (sync, active high), flush (sync queue clear)
//   in_valid/in_instr/in_ready : upstream handshake
//   core_ready                 : core accepts a new word this cycle
//   Instr_out/ALUSrc/RegWrite  : registered instruction and controls
//   out_valid                  : 1 = real instruction, 0 = injected NOP
//   count                      : FIFO occupancy
module esm_fetch_queue
  import esm_pkg::*;
#(
  parameter int unsigned                Instr_word_size = 32,
  parameter int unsigned                depth           = 8,
  parameter logic [Instr_word_size-1:0] NOP_WORD        = esm_pkg::NOP_WORD
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [Instr_word_size-1:0]   in_instr,
  output logic                         in_ready,
  input  logic                         core_ready,
  output logic [Instr_word_size-1:0]   Instr_out,
  output logic                         ALUSrc,
  output logic                         RegWrite,
  output logic                         out_valid,
  output logic [$clog2(depth):0]       count
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(depth);

  logic [Instr_word_size-1:0] mem [depth];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic                       push, pop, empty;
  logic [Instr_word_size-1:0] head;
  ctrl_t                      head_ctrl;

  assign empty    = (count == '0);
  assign in_ready = (count != FULL);
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = core_ready & ~empty & ~flush;
  assign head     = mem[rd_ptr];

  esm_instr_decode #(
    .Instr_word_size(Instr_word_size)
  ) u_decode (
    .instr(head),
    .ctrl (head_ctrl)
  );

  // Storage is not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      Instr_out <= NOP_WORD;
      ALUSrc    <= 1'b1;
      RegWrite  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      if (core_ready) begin
        if (!empty) begin
          Instr_out <= head;
          ALUSrc    <= head_ctrl.ALUSrc;
          RegWrite  <= head_ctrl.RegWrite;
          out_valid <= 1'b1;
        end else begin
          Instr_out <= NOP_WORD;
          ALUSrc    <= 1'b1;
          RegWrite  <= 1'b0;
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
